// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared pipeline types for the decode-side forwarding/hazard controller:
// ALU operand selects, store-data forward select and in-flight tracking slots.
package fwd_hazard_ctrl_pkg;

  localparam int HAZ_RD_W = 5;

  typedef enum logic [1:0] {
    PC_S1    = 2'd0,
    RS1_S1   = 2'd1,
    RD_MA_S1 = 2'd2,
    RD_WB_S1 = 2'd3
  } ctrlAluSrc1_e;

  typedef enum logic [1:0] {
    RS2_S2   = 2'd0,
    IMM_S2   = 2'd1,
    RD_MA_S2 = 2'd2,
    RD_WB_S2 = 2'd3
  } ctrlAluSrc2_e;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_MA   = 2'd1,
    ST_WB   = 2'd2
  } stFwdSel_e;

  typedef struct packed {
    logic                valid;
    logic [HAZ_RD_W-1:0] rd;
    logic                reg_wr;
    logic                mem_rd;
  } hazSlot_s;

  localparam hazSlot_s BUBBLE_SLOT = '0;

  // x0 is hardwired to zero, so a write to it never produces forwardable data.
  function automatic logic slot_writes(input hazSlot_s s, input logic [HAZ_RD_W-1:0] rs);
    return s.valid && s.reg_wr && (s.rd != '0) && (s.rd == rs);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-side decode fields in, registered EX-side operand selects and stall out.
interface fwd_hazard_ctrl_if #(parameter int REG_ADDR_W = 5);
  import fwd_hazard_ctrl_pkg::*;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_wr;
  logic                  id_mem_rd;
  logic                  id_store;
  ctrlAluSrc1_e          id_src1_sel;
  ctrlAluSrc2_e          id_src2_sel;
  logic                  ex_flush;
  logic                  stall;
  logic                  ex_valid;
  ctrlAluSrc1_e          ex_alu_src1;
  ctrlAluSrc2_e          ex_alu_src2;
  stFwdSel_e             ex_st_fwd;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_wr, id_mem_rd, id_store,
           id_src1_sel, id_src2_sel, ex_flush,
    input  stall, ex_valid, ex_alu_src1, ex_alu_src2, ex_st_fwd
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_wr, id_mem_rd, id_store,
           id_src1_sel, id_src2_sel, ex_flush,
    output stall, ex_valid, ex_alu_src1, ex_alu_src2, ex_st_fwd
  );

endinterface

// File: rtl/fwd_hazard_ctrl_src_match.sv
// Compares one source address against both in-flight slots; the EX slot's
// result will sit in MA when the consumer reaches EX, the MA slot's in WB.
module fwd_src_match
  import fwd_hazard_ctrl_pkg::*;
(
  input  hazSlot_s            ex_slot,
  input  hazSlot_s            ma_slot,
  input  logic [HAZ_RD_W-1:0] rs,
  output logic                hit_ma,
  output logic                hit_wb,
  output logic                load_hit
);

  assign hit_ma   = slot_writes(ex_slot, rs);
  assign hit_wb   = slot_writes(ma_slot, rs);
  assign load_hit = hit_ma && ex_slot.mem_rd;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-side forwarding and load-use hazard control feeding the ID/EX register:
// tracks the two older in-flight writers and registers the EX operand selects.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_REGS   = 32
) (
  input logic               clk,
  input logic               rst,
  input logic               clk_en,
  fwd_hazard_ctrl_if.slave  bus
);

  if (REG_ADDR_W != HAZ_RD_W || NUM_REGS > (1 << REG_ADDR_W)) begin : g_param_check
    $error("fwd_hazard_ctrl: register address width does not match the tracking slots");
  end

  hazSlot_s     ex_slot_reg, ex_slot_next;
  hazSlot_s     ma_slot_reg, ma_slot_next;
  logic         valid_reg, valid_next;
  ctrlAluSrc1_e src1_reg, src1_next;
  ctrlAluSrc2_e src2_reg, src2_next;
  stFwdSel_e    st_reg, st_next;

  logic [1:0][HAZ_RD_W-1:0] rs_addr;
  logic [1:0]               hit_ma, hit_wb, load_hit;

  assign rs_addr[0] = bus.id_rs1;
  assign rs_addr[1] = bus.id_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_match
      fwd_src_match u_match (
        .ex_slot  (ex_slot_reg),
        .ma_slot  (ma_slot_reg),
        .rs       (rs_addr[gi]),
        .hit_ma   (hit_ma[gi]),
        .hit_wb   (hit_wb[gi]),
        .load_hit (load_hit[gi])
      );
    end
  endgenerate

  ctrlAluSrc1_e base1, sel1;
  ctrlAluSrc2_e base2, sel2;
  stFwdSel_e    sel_st;
  logic         rs1_used, rs2_used, stall;

  // Forwarding selects; decoder-illegal forward codes collapse to the register source.
  always_comb begin
    base1    = (bus.id_src1_sel == PC_S1) ? PC_S1 : RS1_S1;
    base2    = (bus.id_src2_sel == IMM_S2) ? IMM_S2 : RS2_S2;
    rs1_used = (base1 == RS1_S1);
    rs2_used = (base2 == RS2_S2) || bus.id_store;

    sel1 = base1;
    if (rs1_used) begin
      if (hit_ma[0])      sel1 = RD_MA_S1;
      else if (hit_wb[0]) sel1 = RD_WB_S1;
    end

    sel2 = base2;
    if (base2 == RS2_S2) begin
      if (hit_ma[1])      sel2 = RD_MA_S2;
      else if (hit_wb[1]) sel2 = RD_WB_S2;
    end

    sel_st = ST_NONE;
    if (bus.id_store) begin
      if (hit_ma[1])      sel_st = ST_MA;
      else if (hit_wb[1]) sel_st = ST_WB;
    end

    // Load data only exists after MA, so an EX-slot load hit costs one bubble.
    stall = bus.id_valid && !bus.ex_flush &&
            ((rs1_used && load_hit[0]) || (rs2_used && load_hit[1]));
  end

  always_comb begin
    ex_slot_next = ex_slot_reg;
    ma_slot_next = ma_slot_reg;
    valid_next   = valid_reg;
    src1_next    = src1_reg;
    src2_next    = src2_reg;
    st_next      = st_reg;
    if (clk_en) begin
      ma_slot_next = ex_slot_reg;
      if (bus.ex_flush || stall || !bus.id_valid) begin
        ex_slot_next = BUBBLE_SLOT;
        valid_next   = 1'b0;
        src1_next    = RS1_S1;
        src2_next    = RS2_S2;
        st_next      = ST_NONE;
      end else begin
        ex_slot_next.valid  = 1'b1;
        ex_slot_next.rd     = bus.id_rd;
        ex_slot_next.reg_wr = bus.id_reg_wr;
        ex_slot_next.mem_rd = bus.id_mem_rd;
        valid_next          = 1'b1;
        src1_next           = sel1;
        src2_next           = sel2;
        st_next             = sel_st;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_slot_reg <= BUBBLE_SLOT;
      ma_slot_reg <= BUBBLE_SLOT;
      valid_reg   <= 1'b0;
      src1_reg    <= RS1_S1;
      src2_reg    <= RS2_S2;
      st_reg      <= ST_NONE;
    end else begin
      ex_slot_reg <= ex_slot_next;
      ma_slot_reg <= ma_slot_next;
      valid_reg   <= valid_next;
      src1_reg    <= src1_next;
      src2_reg    <= src2_next;
      st_reg      <= st_next;
    end
  end

  assign bus.stall       = stall;
  assign bus.ex_valid    = valid_reg;
  assign bus.ex_alu_src1 = src1_reg;
  assign bus.ex_alu_src2 = src2_reg;
  assign bus.ex_st_fwd   = st_reg;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed program fragments plus randomized instruction streams checked against
// a model that looks up the most recent older producer of each source register.
module tb_fwd_hazard_ctrl;
  import fwd_hazard_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic clk_en;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(5)) bus ();

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .NUM_REGS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit valid;
    int rd;
    bit wr;
    bit ld;
  } instr_t;

  // older[0]: one instruction ahead (in EX); older[1]: two ahead (in MA)
  instr_t older[2];
  int     exp_valid, exp_s1, exp_s2, exp_st;
  int     n_checks = 0;
  int     n_fail   = 0;
  int     txn      = 0;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL txn=%0d %s: got %0d expected %0d", txn, tag, got, want);
    end
  endtask

  // 0 = no older producer, 1 = one instruction ahead, 2 = two ahead
  function automatic int producer(input int rs);
    for (int d = 0; d < 2; d++)
      if (older[d].valid && older[d].wr && older[d].rd != 0 && older[d].rd == rs)
        return d + 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) older[d] = '{0, 0, 0, 0};
    exp_valid = 0;
    exp_s1    = int'(RS1_S1);
    exp_s2    = int'(RS2_S2);
    exp_st    = int'(ST_NONE);
  endtask

  task automatic step(input bit v, input int rs1, input int rs2, input int rd,
                      input bit wr, input bit ld, input bit st,
                      input logic [1:0] s1, input logic [1:0] s2,
                      input bit fl, input bit en, input bit r);
    bit     use1, use2, exp_stall;
    int     p1, p2;
    instr_t nw;
    bus.id_valid    = v;
    bus.id_rs1      = 5'(rs1);
    bus.id_rs2      = 5'(rs2);
    bus.id_rd       = 5'(rd);
    bus.id_reg_wr   = wr;
    bus.id_mem_rd   = ld;
    bus.id_store    = st;
    bus.id_src1_sel = ctrlAluSrc1_e'(s1);
    bus.id_src2_sel = ctrlAluSrc2_e'(s2);
    bus.ex_flush    = fl;
    clk_en          = en;
    rst             = r;
    #2;
    use1 = (s1 != 2'(PC_S1));
    use2 = (s2 != 2'(IMM_S2)) || st;
    p1   = producer(rs1);
    p2   = producer(rs2);
    exp_stall = v && !fl && ((use1 && p1 == 1 && older[0].ld) ||
                             (use2 && p2 == 1 && older[0].ld));
    check_eq("stall", int'(bus.stall), int'(exp_stall));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (en) begin
      if (!v || fl || exp_stall) begin
        nw        = '{0, 0, 0, 0};
        exp_valid = 0;
        exp_s1    = int'(RS1_S1);
        exp_s2    = int'(RS2_S2);
        exp_st    = int'(ST_NONE);
      end else begin
        nw        = '{1, rd, wr, ld};
        exp_valid = 1;
        if (!use1)        exp_s1 = int'(PC_S1);
        else if (p1 == 1) exp_s1 = int'(RD_MA_S1);
        else if (p1 == 2) exp_s1 = int'(RD_WB_S1);
        else              exp_s1 = int'(RS1_S1);
        if (s2 == 2'(IMM_S2)) exp_s2 = int'(IMM_S2);
        else if (p2 == 1)     exp_s2 = int'(RD_MA_S2);
        else if (p2 == 2)     exp_s2 = int'(RD_WB_S2);
        else                  exp_s2 = int'(RS2_S2);
        if (!st)          exp_st = int'(ST_NONE);
        else if (p2 == 1) exp_st = int'(ST_MA);
        else if (p2 == 2) exp_st = int'(ST_WB);
        else              exp_st = int'(ST_NONE);
      end
      older[1] = older[0];
      older[0] = nw;
    end
    #1;
    check_eq("ex_valid", int'(bus.ex_valid), exp_valid);
    check_eq("ex_alu_src1", int'(bus.ex_alu_src1), exp_s1);
    check_eq("ex_alu_src2", int'(bus.ex_alu_src2), exp_s2);
    check_eq("ex_st_fwd", int'(bus.ex_st_fwd), exp_st);
    $display("txn %0d v=%0b rs1=%0d rs2=%0d rd=%0d fl=%0b en=%0b rst=%0b -> stall=%0b ex_valid=%0b src1=%0d src2=%0d st=%0d",
             txn, v, rs1, rs2, rd, fl, en, r, exp_stall, bus.ex_valid,
             bus.ex_alu_src1, bus.ex_alu_src2, bus.ex_st_fwd);
    txn++;
  endtask

  localparam logic [1:0] PC = 2'd0, R1 = 2'd1, R2 = 2'd0, IM = 2'd1;

  // ALU op rd,rs1,rs2 / immediate op / load / store / nop shorthands
  task automatic alu(input int rd, input int a, input int b);
    step(1, a, b, rd, 1, 0, 0, R1, R2, 0, 1, 0);
  endtask
  task automatic alui(input int rd, input int a);
    step(1, a, 0, rd, 1, 0, 0, R1, IM, 0, 1, 0);
  endtask
  task automatic load(input int rd, input int a);
    step(1, a, 0, rd, 1, 1, 0, R1, IM, 0, 1, 0);
  endtask
  task automatic store(input int a, input int d);
    step(1, a, d, 0, 0, 0, 1, R1, IM, 0, 1, 0);
  endtask
  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 1, 0);
  endtask

  initial begin
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, R1, R2, 0, 0, 1);

    // Back-to-back, distance-2, double hit
    alu(5, 1, 2); alu(6, 5, 3);
    alu(5, 1, 2); nop(); alu(7, 4, 5);
    alu(5, 1, 2); alu(5, 2, 3); alu(7, 4, 5);
    // Load-use: stalled instruction is presented again
    load(8, 1); alu(9, 8, 8); alu(9, 8, 8);
    // x0 and store data
    alui(0, 1); alu(2, 0, 0);
    alu(5, 1, 2); store(1, 5);
    load(5, 1); store(1, 5); store(1, 5);
    // Flush beats stall, then clock-enable hold
    load(8, 1); step(1, 8, 8, 9, 1, 0, 0, R1, R2, 1, 1, 0);
    alu(5, 1, 2);
    for (int i = 0; i < 3; i++) step(1, 5, 5, 6, 1, 0, 0, R1, R2, 0, 0, 0);
    alu(6, 5, 5);
    // Reset during a stall
    load(8, 1); step(1, 8, 2, 9, 1, 0, 0, R1, R2, 0, 1, 1); alu(9, 8, 2);
    // Illegal base selects and PC source
    alu(3, 1, 1); step(1, 3, 3, 4, 1, 0, 0, 2'd3, 2'd2, 0, 1, 0);
    step(1, 3, 3, 4, 1, 0, 0, PC, R2, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      bit ld_r;
      ld_r = ($urandom_range(0, 3) == 0);
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           ld_r || ($urandom_range(0, 3) != 0), ld_r,
           $urandom_range(0, 4) == 0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 49) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
